// File: rtl/dma_slot_scheduler.sv
// Colour-clock chip-bus slot allocator: fixed-slot DMA channels plus prioritised
// arbitration of free slots, with a CPU anti-starvation limit on the blitter.
module dma_slot_scheduler #(
    parameter int NSPR    = 8,
    parameter int BLT_MAX = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cck,
    input  logic [7:0] hpos,
    input  logic       dmaen,
    input  logic       dskdma,
    input  logic       sprdma,
    input  logic       bpldma,
    input  logic       copdma,
    input  logic       blten,
    input  logic [3:0] auddma,
    input  logic       bltpri,
    input  logic       dsk_req,
    input  logic       spr_req,
    input  logic       bpl_req,
    input  logic       cop_req,
    input  logic       blt_req,
    input  logic       cpu_req,
    input  logic [3:0] aud_req,
    output logic       gnt_ref,
    output logic       gnt_dsk,
    output logic       gnt_spr,
    output logic       gnt_bpl,
    output logic       gnt_cop,
    output logic       gnt_blt,
    output logic       gnt_cpu,
    output logic [3:0] gnt_aud,
    output logic [2:0] spr_num,
    output logic       slot_free
);

    typedef enum logic [3:0] {
        OWN_NONE = 4'd0,
        OWN_REF  = 4'd1,
        OWN_DSK  = 4'd2,
        OWN_AUD  = 4'd3,
        OWN_SPR  = 4'd4,
        OWN_BPL  = 4'd5,
        OWN_COP  = 4'd6,
        OWN_BLT  = 4'd7,
        OWN_CPU  = 4'd8
    } owner_e;

    localparam logic [7:0] AUD_BASE  = 8'h0D;
    localparam logic [7:0] SPR_BASE  = 8'h15;
    localparam logic [8:0] SPR_END   = 9'(9'h015 + 9'(4 * NSPR));
    localparam logic [7:0] COP_BLOCK = 8'hE0;
    localparam logic [1:0] BLT_LIMIT = 2'(BLT_MAX);

    logic       ref_slot_s;
    logic       dsk_slot_s;
    logic       aud_slot_s;
    logic       spr_slot_s;
    logic [1:0] aud_idx_s;
    logic [2:0] spr_idx_s;
    logic       dsk_ok_s;
    logic       aud_ok_s;
    logic       spr_ok_s;
    logic       bpl_ok_s;
    logic       cop_ok_s;
    logic       blt_ok_s;
    owner_e     owner_s;
    logic [1:0] starve_r;
    logic [1:0] starve_nxt_s;

    // Decode which fixed channel, if any, owns the current beam position.
    always_comb begin
        ref_slot_s = (hpos == 8'hE2) || (hpos == 8'h01) || (hpos == 8'h03) || (hpos == 8'h05);
        dsk_slot_s = (hpos == 8'h07) || (hpos == 8'h09) || (hpos == 8'h0B);
        aud_slot_s = hpos[0] && (hpos >= AUD_BASE) && (hpos <= 8'h13);
        spr_slot_s = hpos[0] && (hpos >= SPR_BASE) && ({1'b0, hpos} < SPR_END);
        aud_idx_s  = 2'((hpos - AUD_BASE) >> 1);
        spr_idx_s  = 3'((hpos - SPR_BASE) >> 2);
    end

    // Per-requester eligibility; the blitter steps aside once the CPU has waited long enough.
    always_comb begin
        dsk_ok_s = dsk_slot_s && dmaen && dskdma && dsk_req;
        aud_ok_s = aud_slot_s && dmaen && auddma[aud_idx_s] && aud_req[aud_idx_s];
        spr_ok_s = spr_slot_s && dmaen && sprdma && spr_req && !bpl_req;
        bpl_ok_s = dmaen && bpldma && bpl_req;
        cop_ok_s = dmaen && copdma && cop_req && !hpos[0] && (hpos != COP_BLOCK);
        blt_ok_s = dmaen && blten && blt_req
                   && !((starve_r == BLT_LIMIT) && !bltpri && cpu_req);
    end

    // Slot owner: refresh, disk and audio beat everyone; sprites only when bitplanes are idle.
    always_comb begin
        owner_s = OWN_NONE;
        if (ref_slot_s) begin
            owner_s = OWN_REF;
        end else if (dsk_ok_s) begin
            owner_s = OWN_DSK;
        end else if (aud_ok_s) begin
            owner_s = OWN_AUD;
        end else if (spr_ok_s) begin
            owner_s = OWN_SPR;
        end else if (bpl_ok_s) begin
            owner_s = OWN_BPL;
        end else if (cop_ok_s) begin
            owner_s = OWN_COP;
        end else if (blt_ok_s) begin
            owner_s = OWN_BLT;
        end else if (cpu_req) begin
            owner_s = OWN_CPU;
        end else begin
            owner_s = OWN_NONE;
        end
    end

    // Count blitter grants taken while the CPU is kept waiting.
    always_comb begin
        starve_nxt_s = starve_r;
        if (bltpri) begin
            starve_nxt_s = 2'd0;
        end else if ((owner_s == OWN_CPU) || !cpu_req) begin
            starve_nxt_s = 2'd0;
        end else if ((owner_s == OWN_BLT) && (starve_r != 2'd3)) begin
            starve_nxt_s = starve_r + 2'd1;
        end else begin
            starve_nxt_s = starve_r;
        end
    end

    // Register the grant set once per CCK; outputs hold between evaluations.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_ref   <= 1'b0;
            gnt_dsk   <= 1'b0;
            gnt_aud   <= 4'b0000;
            gnt_spr   <= 1'b0;
            gnt_bpl   <= 1'b0;
            gnt_cop   <= 1'b0;
            gnt_blt   <= 1'b0;
            gnt_cpu   <= 1'b0;
            spr_num   <= 3'd0;
            slot_free <= 1'b0;
            starve_r  <= 2'd0;
        end else if (cck) begin
            gnt_ref   <= 1'b0;
            gnt_dsk   <= 1'b0;
            gnt_aud   <= 4'b0000;
            gnt_spr   <= 1'b0;
            gnt_bpl   <= 1'b0;
            gnt_cop   <= 1'b0;
            gnt_blt   <= 1'b0;
            gnt_cpu   <= 1'b0;
            spr_num   <= 3'd0;
            slot_free <= 1'b0;
            starve_r  <= starve_nxt_s;
            case (owner_s)
                OWN_REF: gnt_ref <= 1'b1;
                OWN_DSK: gnt_dsk <= 1'b1;
                OWN_AUD: gnt_aud <= 4'b0001 << aud_idx_s;
                OWN_SPR: begin
                    gnt_spr <= 1'b1;
                    spr_num <= spr_idx_s;
                end
                OWN_BPL: gnt_bpl <= 1'b1;
                OWN_COP: gnt_cop <= 1'b1;
                OWN_BLT: gnt_blt <= 1'b1;
                OWN_CPU: gnt_cpu <= 1'b1;
                default: slot_free <= 1'b1;
            endcase
        end else begin
            starve_r <= starve_r;
        end
    end

endmodule
